// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweep of a small combinational DUT
// Applies every input vector in ascending order and scores the settled response against EXPECT.
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int DWELL = 4,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = 16'h8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_OUT-1:0]  resp,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  state_t            state, state_nxt;
  logic [7:0]        dwell_cnt, dwell_nxt;
  logic [N_IN-1:0]   stim_nxt, first_err_vec_nxt;
  logic [N_IN:0]     err_count_nxt;
  logic              first_err_valid_nxt;
  logic [N_OUT-1:0]  exp_resp;
  logic              mismatch;

  assign exp_resp = EXPECT[stim*N_OUT +: N_OUT];
  assign mismatch = (resp != exp_resp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      dwell_cnt       <= '0;
      stim            <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      state           <= state_nxt;
      dwell_cnt       <= dwell_nxt;
      stim            <= stim_nxt;
      err_count       <= err_count_nxt;
      first_err_valid <= first_err_valid_nxt;
      first_err_vec   <= first_err_vec_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    dwell_nxt           = dwell_cnt;
    stim_nxt            = stim;
    err_count_nxt       = err_count;
    first_err_valid_nxt = first_err_valid;
    first_err_vec_nxt   = first_err_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt           = RUN;
          dwell_nxt           = '0;
          stim_nxt            = '0;
          err_count_nxt       = '0;
          first_err_valid_nxt = 1'b0;
          first_err_vec_nxt   = '0;
        end
      end
      RUN: begin
        // Only the last cycle of each dwell is scored; earlier cycles let the DUT settle.
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (mismatch) begin
            err_count_nxt = err_count + (N_IN+1)'(1);
            if (!first_err_valid) begin
              first_err_valid_nxt = 1'b1;
              first_err_vec_nxt   = stim;
            end
          end
          if (stim == VEC_LAST) begin
            state_nxt = DONE;
            stim_nxt  = '0;
          end else begin
            stim_nxt = stim + N_IN'(1);
          end
        end else begin
          dwell_nxt = dwell_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - directed bench for truth_table_sweeper
// Default 4-input AND sweeper plus a 3-input full-adder sweeper with two outputs.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // default instance: 4 inputs, 1 output, dwell 4, AND table
  logic       start = 1'b0;
  logic       resp;
  logic [3:0] stim;
  logic       busy, done, pass, fev_valid;
  logic [4:0] err_count;
  logic [3:0] fev;
  int         mode = 0;
  int         sw_cyc = 0;
  logic       good;

  // adder instance: {carry,sum} table
  logic       start2 = 1'b0;
  logic [1:0] resp2;
  logic [2:0] stim2;
  logic       busy2, done2, pass2, fev_valid2;
  logic [3:0] err_count2;
  logic [2:0] fev2;
  int         mode2 = 0;
  logic [1:0] add_good;

  truth_table_sweeper u_dut (
    .clk(clk), .rst(rst), .start(start), .resp(resp), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev_valid), .first_err_vec(fev)
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .DWELL(2), .EXPECT(16'hE994)) u_add (
    .clk(clk), .rst(rst), .start(start2), .resp(resp2), .stim(stim2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_valid(fev_valid2), .first_err_vec(fev2)
  );

  // cycles since the last start edge; drives the glitching responder
  always @(posedge clk) sw_cyc <= start ? 0 : sw_cyc + 1;

  always_comb begin
    good = &stim;
    case (mode)
      1:       resp = |stim;
      2:       resp = ((sw_cyc % 4) == 3) ? good : ~good;
      default: resp = good;
    endcase
    add_good = 2'(stim2[2]) + 2'(stim2[1]) + 2'(stim2[0]);
    resp2 = (mode2 == 1) ? (add_good & 2'b10) : add_good;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Called at the negedge just after the start edge; walks the 64-cycle sweep.
  task automatic sweep_body(input bit restarts, input int exp_err, input int exp_fev);
    chk("stim_at_start", stim, 0);
    chk("busy_at_start", busy, 1);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (restarts) start = (i == 10 || i == 40);
      chk($sformatf("stim_c%0d", i), stim, (i < 64) ? i / 4 : 0);
      chk($sformatf("done_c%0d", i), done, (i == 64) ? 1 : 0);
    end
    start = 1'b0;
    chk("busy_end", busy, 0);
    chk("pass_end", pass, (exp_err == 0) ? 1 : 0);
    chk("err_count_end", err_count, exp_err);
    chk("fev_valid_end", fev_valid, (exp_err != 0) ? 1 : 0);
    chk("fev_end", fev, exp_fev);
  endtask

  task automatic adder_sweep(input int exp_err, input int exp_fev);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("add_stim_c%0d", i), stim2, (i < 16) ? i / 2 : 0);
      chk($sformatf("add_done_c%0d", i), done2, (i == 16) ? 1 : 0);
    end
    chk("add_pass", pass2, (exp_err == 0) ? 1 : 0);
    chk("add_err_count", err_count2, exp_err);
    chk("add_fev_valid", fev_valid2, (exp_err != 0) ? 1 : 0);
    chk("add_fev", fev2, exp_fev);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"}, stim, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_fevv"}, fev_valid, 0);
    chk({tag, "_fev"}, fev, 0);
  endtask

  initial begin
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("idle");

    // correct AND gate
    mode = 0;
    pulse_start();
    sweep_body(1'b0, 0, 0);

    // wrong gate: OR differs from AND on vectors 1..14
    mode = 1;
    pulse_start();
    sweep_body(1'b0, 14, 1);

    // results frozen in DONE whatever resp does
    mode = 0;
    repeat (5) @(negedge clk);
    chk("hold_err", err_count, 14);
    chk("hold_done", done, 1);
    chk("hold_fev", fev, 1);

    // start in DONE clears results on that edge and restarts at vector 0
    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_fevv", fev_valid, 0);
    sweep_body(1'b0, 0, 0);

    // start pulses during RUN are ignored
    pulse_start();
    sweep_body(1'b1, 0, 0);

    // asynchronous reset mid-sweep, then a fresh sweep
    mode = 1;
    pulse_start();
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("start_in_rst_busy", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    mode = 0;
    @(negedge clk);
    chk_all_zero("post_rst");
    pulse_start();
    sweep_body(1'b0, 0, 0);

    // response wrong during settling cycles only
    mode = 2;
    pulse_start();
    sweep_body(1'b0, 0, 0);

    // full adder: correct, then sum stuck at 0 (fails on vectors 1,2,4,7)
    mode2 = 0;
    adder_sweep(0, 0);
    mode2 = 1;
    adder_sweep(4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N_IN, default 4: number of DUT inputs driven; legal range 1..8.
REQ-002 Parameter N_OUT, default 1: number of DUT outputs checked; legal range 1..4.
REQ-003 Parameter DWELL, default 4: clock cycles each input vector is held; legal range 2..255.
REQ-004 Parameter EXPECT, width N_OUT*2^N_IN, default 16'h8000 (4-input AND): expected-response table; response for vector v is EXPECT[v*N_OUT +: N_OUT].
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous and active-high.
REQ-007 start  input  1  sweep request, sampled on rising edge.
REQ-008 resp  input  N_OUT  DUT response under test.
REQ-009 stim  output  N_IN  vector applied to DUT; stim[N_IN-1] drives the DUT's first input.
REQ-010 busy  output  1  high while a sweep is running.
REQ-011 done  output  1  high once a sweep has completed; held until the next start or reset.
REQ-012 pass  output  1  high only when done=1 and err_count=0.
REQ-013 err_count  output  N_IN+1  number of mismatching vectors in the current/last sweep.
REQ-014 first_err_valid  output  1  high once at least one mismatch has been recorded.
REQ-015 first_err_vec  output  N_IN  lowest-numbered mismatching vector; 0 when first_err_valid=0.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-017 IDLE: stim=0, busy=0, done=0; start=1 at edge k -> RUN, stim=0, dwell counter=0, err_count/first_err cleared.
REQ-018 RUN: vectors SHALL be applied in ascending binary order 0 .. 2^N_IN-1, each held exactly DWELL cycles.
REQ-019 Sampling: at the edge where dwell counter = DWELL-1, resp SHALL be compared against the expected value for the current stim; earlier cycles in the dwell are settling time and are not checked.
REQ-020 On mismatch: err_count increments by 1 at that edge; if first_err_valid=0, first_err_vec takes current stim and first_err_valid sets at the same edge.
REQ-021 After sampling vector v < 2^N_IN-1: stim becomes v+1 and dwell counter returns to 0 at the same edge.
REQ-022 After sampling vector 2^N_IN-1: state -> DONE, busy=0, done=1; stim returns to 0; done asserted exactly 2^N_IN*DWELL cycles after edge k.
REQ-023 err_count SHALL NOT wrap; max value 2^N_IN fits in N_IN+1 bits.
REQ-024 start while RUN SHALL be ignored; sweep continues unaffected.
REQ-025 start while DONE SHALL begin a new sweep exactly as from IDLE, clearing done, pass, err_count and first_err at that edge.
REQ-026 Result outputs SHALL remain stable in DONE regardless of resp.
REQ-027 resp is assumed synchronous to clk; no internal synchroniser.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0.
REQ-029 rst asserted mid-sweep SHALL abort the sweep; no partial results survive; start is ignored while rst=1.
REQ-030 After rst release, the first start seen on a rising edge SHALL begin a full sweep from vector 0.

Verification
REQ-031 Defaults, DUT = correct 4-input AND, start pulse -> stim steps 0..15 every 4 cycles, done=1 after 64 cycles, pass=1, err_count=0, first_err_valid=0.
REQ-032 Defaults, DUT = 4-input OR (wrong gate) -> done after 64 cycles, pass=0, err_count=14, first_err_vec=1, first_err_valid=1.
REQ-033 rst pulsed asynchronously (mid-cycle) at cycle 30 of a sweep -> all outputs zero before next edge; fresh start -> full 64-cycle sweep, correct results.
REQ-034 start re-pulsed at cycles 10 and 40 of a sweep -> no effect, done still at cycle 64; start in DONE -> done drops next edge, new sweep begins at stim=0.
REQ-035 N_IN=3, N_OUT=2, DWELL=2, EXPECT = full-adder {carry,sum}, correct adder -> pass after 16 cycles; sum bit stuck at 0 -> err_count=4, first_err_vec=1.
REQ-036 Glitch check, DWELL=4: resp wrong during dwell cycles 0..2 but correct in cycle 3 for every vector -> pass=1.
